ram_stream_loader: RTL and testbench

- Upstream feeder for the 256x32 single-port RAM: it accepts a valid/ready word stream and writes the words to consecutive RAM addresses from a commanded base.
- It drives the RAM's we/adr/din directly, with all RAM-side outputs registered.
- A command interface (start pulse, base, length) frames each burst. Status outputs report busy, completion and word count.
- It sits between the stream producer (host/DMA side) and the RAM.

---
 rtl/ram_stream_loader_pkg.sv | 14 +
 rtl/ram_stream_loader.sv | 128 ++++++++++++
 tb/tb_ram_stream_loader.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/ram_stream_loader_pkg.sv
// Shared types and default sizing for the RAM stream loader.
package ram_stream_loader_pkg;

  localparam int RSL_DATA_W = 32;
  localparam int RSL_ADDR_W = 8;
  localparam int RSL_DEPTH  = 2 ** RSL_ADDR_W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } rsl_state_e;

endpackage

// File: rtl/ram_stream_loader.sv
// Streams valid/ready words into consecutive RAM addresses from a commanded base.
// Optional running checksum enabled by RAM_STREAM_LOADER_CSUM_EN.
module ram_stream_loader
  import ram_stream_loader_pkg::*;
#(
  parameter int DATA_W = RSL_DATA_W,
  parameter int ADDR_W = RSL_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_start,
  input  logic [ADDR_W-1:0] cmd_base,
  input  logic [ADDR_W:0]   cmd_len,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  input  logic              abort,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_adr,
  output logic [DATA_W-1:0] ram_din,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   count,
  output logic [DATA_W-1:0] csum
);

  localparam logic [ADDR_W:0]   CNT_ONE  = 1;
  localparam logic [ADDR_W-1:0] ADDR_ONE = 1;

  rsl_state_e        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W:0]   len_q, len_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              ram_we_q, ram_we_d;
  logic [ADDR_W-1:0] ram_adr_q, ram_adr_d;
  logic [DATA_W-1:0] ram_din_q, ram_din_d;
  logic              accept;

  // Handshake qualifiers come from the state register only.
  assign s_ready = (state_q == LOAD);
  assign busy    = (state_q != IDLE);
  assign done    = (state_q == DONE);
  assign ram_we  = ram_we_q;
  assign ram_adr = ram_adr_q;
  assign ram_din = ram_din_q;
  assign count   = count_q;

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    len_d     = len_q;
    count_d   = count_q;
    ram_we_d  = 1'b0;
    ram_adr_d = ram_adr_q;
    ram_din_d = ram_din_q;
    accept    = 1'b0;
    case (state_q)
      IDLE: begin
        if (cmd_start) begin
          count_d = '0;
          if (cmd_len != '0) begin
            addr_d  = cmd_base;
            len_d   = cmd_len;
            state_d = LOAD;
          end else begin
            state_d = DONE;
          end
        end
      end
      LOAD: begin
        // abort wins over a word offered in the same cycle
        if (abort) begin
          state_d = DONE;
        end else if (s_valid) begin
          accept    = 1'b1;
          ram_we_d  = 1'b1;
          ram_adr_d = addr_q;
          ram_din_d = s_data;
          addr_d    = addr_q + ADDR_ONE;
          count_d   = count_q + CNT_ONE;
          if (count_q + CNT_ONE == len_q) state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      len_q     <= '0;
      count_q   <= '0;
      ram_we_q  <= 1'b0;
      ram_adr_q <= '0;
      ram_din_q <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      len_q     <= len_d;
      count_q   <= count_d;
      ram_we_q  <= ram_we_d;
      ram_adr_q <= ram_adr_d;
      ram_din_q <= ram_din_d;
    end
  end

`ifdef RAM_STREAM_LOADER_CSUM_EN
  logic [DATA_W-1:0] csum_q, csum_d;

  always_comb begin
    csum_d = csum_q;
    if (state_q == IDLE && cmd_start) csum_d = '0;
    else if (accept)                  csum_d = csum_q + s_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) csum_q <= '0;
    else        csum_q <= csum_d;
  end

  assign csum = csum_q;
`else
  assign csum = '0;
`endif

endmodule

// File: tb/tb_ram_stream_loader.sv
// Scoreboard bench: stimulus queues expected RAM writes, a negedge monitor checks them.
module tb_ram_stream_loader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_start;
  logic [7:0]  cmd_base;
  logic [8:0]  cmd_len;
  logic        s_valid;
  logic        s_ready;
  logic [31:0] s_data;
  logic        abort;
  logic        ram_we;
  logic [7:0]  ram_adr;
  logic [31:0] ram_din;
  logic        busy;
  logic        done;
  logic [8:0]  count;
  logic [31:0] csum;

`ifdef RAM_STREAM_LOADER_CSUM_EN
  localparam bit CSUM_ON = 1'b1;
`else
  localparam bit CSUM_ON = 1'b0;
`endif

  typedef struct {
    logic [7:0]  adr;
    logic [31:0] data;
    logic        last;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;

  ram_stream_loader #(.DATA_W(32), .ADDR_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_start(cmd_start), .cmd_base(cmd_base),
    .cmd_len(cmd_len), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .abort(abort), .ram_we(ram_we), .ram_adr(ram_adr), .ram_din(ram_din),
    .busy(busy), .done(done), .count(count), .csum(csum)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1 && ram_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_write", {24'd0, ram_adr}, 32'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("write_adr", {24'd0, ram_adr}, {24'd0, e.adr});
        check("write_din", ram_din, e.data);
        check("write_done_align", {31'd0, done}, {31'd0, e.last});
      end
    end
  end

  task automatic start_cmd(input logic [7:0] base, input logic [8:0] len);
    @(posedge clk); #1;
    cmd_start = 1'b1; cmd_base = base; cmd_len = len;
    @(posedge clk); #1;
    cmd_start = 1'b0;
  endtask

  task automatic wait_ready();
    int k = 0;
    while (!s_ready && k < 20) begin
      @(posedge clk); #1;
      k++;
    end
    if (!s_ready) check("ready_timeout", {31'd0, s_ready}, 32'd1);
  endtask

  task automatic offer(input logic [7:0] adr, input logic [31:0] d, input bit last);
    s_valid = 1'b1; s_data = d;
    wait_ready();
    exp_q.push_back('{adr, d, last});
    @(posedge clk); #1;
  endtask

  task automatic burst(input logic [7:0] base, input logic [8:0] len,
                       input logic [31:0] d [8], input bit gaps);
    logic [7:0] adr;
    adr = base;
    start_cmd(base, len);
    for (int i = 0; i < int'(len); i++) begin
      if (gaps && i > 0) begin
        s_valid = 1'b0;
        @(posedge clk); #1;
      end
      offer(adr, d[i], i == int'(len) - 1);
      adr++;
    end
    s_valid = 1'b0;
    check("done_pulse", {31'd0, done}, 32'd1);
    check("count_final", {23'd0, count}, {23'd0, len});
    @(posedge clk); #1;
    check("done_drop", {31'd0, done}, 32'd0);
    check("busy_drop", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] w [8];
    rst_n = 1'b0; cmd_start = 1'b0; cmd_base = '0; cmd_len = '0;
    s_valid = 1'b0; s_data = '0; abort = 1'b0;
    #12;
    check("rst_s_ready", {31'd0, s_ready}, 32'd0);
    check("rst_ram_we", {31'd0, ram_we}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_ram_adr", {24'd0, ram_adr}, 32'd0);
    check("rst_ram_din", ram_din, 32'd0);
    check("rst_count", {23'd0, count}, 32'd0);
    check("rst_csum", csum, 32'd0);
    #10 rst_n = 1'b1;

    // basic burst
    w = '{50, 2, 7, 9, 0, 0, 0, 0};
    burst(8'd1, 9'd4, w, 1'b0);
    check("csum_basic", csum, CSUM_ON ? 32'd68 : 32'd0);

    // backpressure gaps
    burst(8'd1, 9'd4, w, 1'b1);
    check("csum_gaps", csum, CSUM_ON ? 32'd68 : 32'd0);

    // wrap-around
    w = '{32'h11, 32'h22, 32'h33, 32'h44, 0, 0, 0, 0};
    burst(8'd254, 9'd4, w, 1'b0);
    check("csum_wrap", csum, CSUM_ON ? 32'hAA : 32'd0);

    // zero length: no write, one-cycle done, count cleared
    start_cmd(8'd50, 9'd0);
    check("zero_done", {31'd0, done}, 32'd1);
    check("zero_busy", {31'd0, busy}, 32'd1);
    check("zero_count", {23'd0, count}, 32'd0);
    check("zero_we", {31'd0, ram_we}, 32'd0);
    @(posedge clk); #1;
    check("zero_done_drop", {31'd0, done}, 32'd0);
    check("zero_idle", {31'd0, busy}, 32'd0);

    // abort on the 3rd handshake; cmd_start during DONE ignored
    start_cmd(8'd40, 9'd8);
    offer(8'd40, 32'd5, 1'b0);
    offer(8'd41, 32'd6, 1'b0);
    s_valid = 1'b1; s_data = 32'd7; abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0; s_valid = 1'b0;
    check("abort_done", {31'd0, done}, 32'd1);
    check("abort_we", {31'd0, ram_we}, 32'd0);
    check("abort_count", {23'd0, count}, 32'd2);
    cmd_start = 1'b1; cmd_base = 8'd100; cmd_len = 9'd3;
    @(posedge clk); #1;
    cmd_start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("abort_no_relaunch", {31'd0, busy}, 32'd0);
    check("abort_count_hold", {23'd0, count}, 32'd2);
    check("csum_abort", csum, CSUM_ON ? 32'd11 : 32'd0);

    // reset mid-burst
    start_cmd(8'd20, 9'd6);
    offer(8'd20, 32'd1, 1'b0);
    offer(8'd21, 32'd2, 1'b0);
    @(negedge clk);
    #2 rst_n = 1'b0; s_valid = 1'b0;
    #1;
    check("mid_rst_we", {31'd0, ram_we}, 32'd0);
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    check("mid_rst_count", {23'd0, count}, 32'd0);
    check("mid_rst_ready", {31'd0, s_ready}, 32'd0);
    check("mid_rst_pending", exp_q.size(), 32'd0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    w = '{32'hDEADBEEF, 0, 0, 0, 0, 0, 0, 0};
    burst(8'd10, 9'd1, w, 1'b0);
    check("csum_post_rst", csum, CSUM_ON ? 32'hDEADBEEF : 32'd0);

    repeat (3) @(posedge clk);
    #1;
    check("all_writes_seen", exp_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
